// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the bit-serial shift unit: default widths,
// op encoding as decoded from {funct3[2], funct7[5]}, and FSM states.
package shift_unit_seq_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    // Encoding matches the raw {funct3_2, funct7_5} bits so decode is a cast
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_ILL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_unit_seq_shift_step.sv
// Combinational single-position shifter: moves data one bit left or right,
// inserting the fill bit at the vacated end.
module shift_step
    import shift_unit_seq_pkg::*;
#(
    parameter int W = DEFAULT_XLEN
) (
    input  logic [W-1:0] data,
    input  logic         dir,
    input  logic         fill,
    output logic [W-1:0] shifted
);

    assign shifted = dir ? {fill, data[W-1:1]} : {data[W-2:0], fill};

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle RV32I shifter (SLL/SRL/SRA): one bit position per clock under a
// Start/Done handshake, with a registered result held between operations.
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               Start,
    input  logic               Flush,
    input  logic [XLEN-1:0]    Src1,
    input  logic [SHAMT_W-1:0] Src2,
    input  logic               funct3_2,
    input  logic               funct7_5,
    output logic               Ready,
    output logic               Busy,
    output logic               Done,
    output logic [XLEN-1:0]    Result
);

    state_e             state, state_next;
    op_e                op_in;
    logic               accept;
    logic               shift_en;
    logic               last_step;
    logic               zero_amt;
    logic [XLEN-1:0]    data_q;
    logic [XLEN-1:0]    step_out;
    logic [XLEN-1:0]    result_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_q;
    logic               fill_q;

    assign op_in     = op_e'({funct3_2, funct7_5});
    assign zero_amt  = (Src2 == '0);
    assign last_step = (cnt_q == SHAMT_W'(1));
    assign shift_en  = (state == SHIFT) && !Flush;
    assign Result    = result_q;

    shift_step #(.W(XLEN)) u_step (
        .data    (data_q),
        .dir     (dir_q),
        .fill    (fill_q),
        .shifted (step_out)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts Start just like IDLE so operations can run back-to-back;
    // Flush overrides everything, including a same-cycle Start.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        Ready      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                Ready = 1'b1;
                Done  = (state == DONE);
                if (Start) begin
                    accept     = 1'b1;
                    state_next = (zero_amt || op_in == OP_ILL) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (Flush) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    // Result is only written on the edge that enters DONE, so the partially
    // shifted working register is never visible on the output.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            data_q <= Src1;
            cnt_q  <= Src2;
            dir_q  <= funct3_2;
            fill_q <= (op_in == OP_SRA) && Src1[XLEN-1];
            if (op_in == OP_ILL) begin
                result_q <= '0;
            end else if (zero_amt) begin
                result_q <= Src1;
            end
        end else if (shift_en) begin
            data_q <= step_out;
            cnt_q  <= cnt_q - SHAMT_W'(1);
            if (last_step) begin
                result_q <= step_out;
            end
        end
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle, area-reduced counterpart of the single-cycle barrel shift unit.
- Executes RV32I SLL/SRL/SRA (register and immediate forms) by shifting one bit position per clock under a start/done handshake.
- Sits in the EX stage as an alternative shift resource for small-core configurations; the pipeline stalls on Busy.
- Result is registered and held until the next accepted operation.

Parameters:
- XLEN, 32, datapath width.
- SHAMT_W, 5, shift-amount width, equal to log2(XLEN).

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Start  input  1  request; sampled when Ready=1.
- Flush  input  1  synchronous abort from the hazard unit.
- Src1  input  XLEN  operand to shift.
- Src2  input  SHAMT_W  shift amount (rs2[4:0] or imm[4:0]).
- funct3_2  input  1  0 = left, 1 = right.
- funct7_5  input  1  arithmetic select; valid only with right shift.
- Ready  output  1  block can accept Start (state IDLE or DONE).
- Busy  output  1  operation in progress (state SHIFT).
- Done  output  1  one-cycle pulse; Result is valid.
- Result  output  XLEN  registered shift result.

Behaviour:
- Reset (async, rst=1): state=IDLE, Result=0, Done=0, Busy=0, Ready=1, internal data/count=0.
- Op decode at accept:
  - {funct3_2,funct7_5}=00 gives SLL, zero-fill from the LSB.
  - 10 gives SRL, zero-fill from the MSB.
  - 11 gives SRA; the fill bit is Src1[XLEN-1], captured at accept.
  - 01 is illegal; Result=0 and Done is pulsed with shamt-0 timing.
- States:
  - IDLE: Ready=1. Start=1 loads data=Src1, cnt=Src2, op, fill. If Src2=0 or op is illegal, go to DONE; otherwise go to SHIFT.
  - SHIFT: Busy=1, Ready=0. Each edge shifts data by one in the op direction with the fill bit and decrements cnt. On the edge where cnt=1, perform the final shift, write Result, and go to DONE.
  - DONE: Done=1 for exactly one cycle, Ready=1. Start=1 is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: with Start high in cycle 0, Done is high in cycle shamt+1 (shamt=0 gives 1 cycle; shamt=31 gives 32 cycles).
- Result is updated only on the transition into DONE. It holds between operations and is never visibly partially shifted.
- Start while Busy=1 is ignored; no queueing.
- Operands are captured at accept. Changes to Src1/Src2/funct inputs during SHIFT have no effect.
- Flush=1 in any state forces IDLE on the next edge, with no Done and Result unchanged. Flush has priority over Start in the same cycle.
- Flush during DONE: the Done pulse already asserted completes; the next state is IDLE.
- Reset mid-operation aborts immediately; outputs take their reset values asynchronously.
- Widths: cnt is SHAMT_W bits. Amounts ≥ XLEN are impossible by construction; the shift amount is masked to 5 bits as in the ISA.

Decomposition:
- Shared package holds the op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ILL), the state encoding (IDLE, SHIFT, DONE), and XLEN/SHAMT_W defaults.
- One natural sub-module is shift_step: combinational single-position shifter with inputs data, dir, fill and output data shifted by 1. It is instantiated once in the SHIFT datapath.

Test Plan:
- Reset then SLL: Src1=0x0000_0001, Src2=31, funct=00, Start cycle 0. Expect Done in cycle 32 only, Result=0x8000_0000, Busy high in cycles 1–31.
- SRA sign fill: Src1=0x8000_00F0, Src2=4, funct=11. Expect Done in cycle 5, Result=0xF800_000F. Repeat with funct=10 and expect Result=0x0800_000F.
- Zero shift and illegal op: Src2=0 with Src1=0xDEAD_BEEF gives Done in cycle 1 and Result=0xDEAD_BEEF. funct=01 with Src2=7 gives Done in cycle 1 and Result=0.
- Back-to-back and ignored Start: Start in the DONE cycle with a new op (SRL 0xFFFF_FFFF by 8) is accepted, giving Result=0x00FF_FFFF. Start pulses during SHIFT cause no effect on Result or timing.
- Flush mid-operation: SLL by 20, Flush in cycle 6. Expect IDLE in cycle 7, no Done, Result equal to the prior value. Flush+Start in the same cycle is not accepted.
- Async reset mid-SHIFT: assert rst between edges. Expect Result=0, Busy=0, Done=0, Ready=1 immediately. Release rst, then SRL 0x100 by 8 gives Result=0x1.
